// File: rtl/lcd_fmt_pkg.sv
// Shared types and constants for the LCD number formatter: FSM states,
// ASCII codes, display buffer layout and the reset-image builder.
package lcd_fmt_pkg;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_EMIT, S_COMMIT} state_e;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] STAR  = 8'h2A;

  localparam int CHARS_PER_LINE = 16;
  localparam int LABEL_CHARS    = 8;
  localparam int DIGITS         = 8;

  // char k of the display lives in element k
  typedef logic [2*CHARS_PER_LINE-1:0][7:0] dbuf_t;

  function automatic dbuf_t reset_image(input logic [63:0] l0, input logic [63:0] l1);
    dbuf_t img;
    for (int k = 0; k < LABEL_CHARS; k++) begin
      img[k]                              = l0[63-8*k -: 8];
      img[k+LABEL_CHARS]                  = SPACE;
      img[k+CHARS_PER_LINE]               = l1[63-8*k -: 8];
      img[k+CHARS_PER_LINE+LABEL_CHARS]   = SPACE;
    end
    return img;
  endfunction

endpackage

// File: rtl/lcd_num_formatter_bin2bcd_seq.sv
// Sequential double-dabble engine: one bit per cycle, 8 BCD digits plus a
// sticky overflow flag for any carry beyond the eighth digit.
module bin2bcd_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      bcd_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [31:0]      bcd_q, bcd_d, adj;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 8; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;

    bcd_d = bcd_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (load_i) begin
      bcd_d = '0;
      sh_d  = value_i;
      cnt_d = CW'(WIDTH);
      ovf_d = 1'b0;
    end else if (cnt_q != '0) begin
      bcd_d = {adj[30:0], sh_q[WIDTH-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CW'(1);
      ovf_d = ovf_q | adj[31];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bcd_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // done_o marks the cycle whose closing edge performs the final shift
  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CW'(1));
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/lcd_num_formatter.sv
// Builds the 32-char LCD buffer (label + 8-digit decimal per line) and
// commits it atomically. Define LCDFMT_ZEROPAD_EN to pad with '0' instead of blanks.
module lcd_num_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int          WIDTH  = 24,
  parameter logic [63:0] LABEL0 = "FREQ    ",
  parameter logic [63:0] LABEL1 = "PHASE   "
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value0,
  input  logic [WIDTH-1:0] value1,
  output logic [255:0]     str,
  output logic             busy,
  output logic             done,
  output logic [1:0]       ovf
);

  localparam dbuf_t RESET_IMG = reset_image(LABEL0, LABEL1);
`ifdef LCDFMT_ZEROPAD_EN
  localparam logic [7:0] LEAD_CH = ZERO;
`else
  localparam logic [7:0] LEAD_CH = SPACE;
`endif

  state_e           state_q, state_d;
  logic             ln_q, ln_d;
  logic [WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [2:0]       dig_q, dig_d;
  logic             nz_q, nz_d;
  dbuf_t            shadow_q, shadow_d, str_q, str_d;
  logic [1:0]       ovfp_q, ovfp_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             eng_load, eng_busy, eng_done, eng_ovf;
  logic [31:0]      eng_bcd;
  logic [3:0]       nib;
  logic [7:0]       ch;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_b2b (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (eng_load),
    .value_i (ln_q ? hold1_q : hold0_q),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd),
    .ovf_o   (eng_ovf)
  );

  // dig_q walks most significant digit first
  assign nib = 4'(eng_bcd >> {3'd7 - dig_q, 2'b00});

  always_comb begin
    state_d  = state_q;
    ln_d     = ln_q;
    hold0_d  = hold0_q;
    hold1_d  = hold1_q;
    dig_d    = dig_q;
    nz_d     = nz_q;
    shadow_d = shadow_q;
    str_d    = str_q;
    ovfp_d   = ovfp_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eng_load = 1'b0;
    ch       = ZERO + {4'h0, nib};
    unique case (state_q)
      S_IDLE: if (start) begin
        hold0_d = value0;
        hold1_d = value1;
        busy_d  = 1'b1;
        ln_d    = 1'b0;
        ovfp_d  = 2'b00;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        eng_load = 1'b1;
        dig_d    = '0;
        nz_d     = 1'b0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: if (eng_done || !eng_busy) state_d = S_EMIT;
      S_EMIT: begin
        if (eng_ovf) ch = STAR;
        else if (nib == 4'd0 && !nz_q && dig_q != 3'd7) ch = LEAD_CH;
        nz_d   = nz_q | (nib != 4'd0);
        // line 0 digits at chars 8..15, line 1 at 24..31
        shadow_d[{ln_q, 1'b1, dig_q}] = ch;
        ovfp_d[ln_q] = eng_ovf;
        dig_d  = dig_q + 3'd1;
        if (dig_q == 3'd7) begin
          if (ln_q) state_d = S_COMMIT;
          else begin
            ln_d    = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_COMMIT: begin
        str_d   = shadow_q;
        ovf_d   = ovfp_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ln_q     <= 1'b0;
      hold0_q  <= '0;
      hold1_q  <= '0;
      dig_q    <= '0;
      nz_q     <= 1'b0;
      shadow_q <= RESET_IMG;
      str_q    <= RESET_IMG;
      ovfp_q   <= 2'b00;
      ovf_q    <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ln_q     <= ln_d;
      hold0_q  <= hold0_d;
      hold1_q  <= hold1_d;
      dig_q    <= dig_d;
      nz_q     <= nz_d;
      shadow_q <= shadow_d;
      str_q    <= str_d;
      ovfp_q   <= ovfp_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign str  = str_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Bench for lcd_num_formatter: WIDTH=24 and WIDTH=28 instances, cycle-level
// reference model compared every cycle, plus directed literal checks.
module tb_lcd_num_formatter;

  localparam int          WA  = 24;
  localparam int          WB  = 28;
  localparam logic [63:0] L0  = "FREQ    ";
  localparam logic [63:0] L1  = "PHASE   ";
  localparam logic [63:0] SP8 = "        ";
`ifdef LCDFMT_ZEROPAD_EN
  localparam logic [7:0]  LEADC  = 8'h30;
  localparam logic [63:0] E_ZERO = "00000000";
  localparam logic [63:0] E_1234 = "01234567";
  localparam logic [63:0] E_5    = "00000005";
  localparam logic [63:0] E_11   = "00000011";
  localparam logic [63:0] E_42   = "00000042";
`else
  localparam logic [7:0]  LEADC  = 8'h20;
  localparam logic [63:0] E_ZERO = "       0";
  localparam logic [63:0] E_1234 = " 1234567";
  localparam logic [63:0] E_5    = "       5";
  localparam logic [63:0] E_11   = "      11";
  localparam logic [63:0] E_42   = "      42";
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st [2];
  logic [31:0] v0 [2];
  logic [31:0] v1 [2];
  logic [255:0] str_a, str_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [1:0]  ovf_a, ovf_b;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  lcd_num_formatter #(.WIDTH(WA)) dut_a (
    .clk(clk), .reset(reset), .start(st[0]),
    .value0(v0[0][WA-1:0]), .value1(v1[0][WA-1:0]),
    .str(str_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  lcd_num_formatter #(.WIDTH(WB)) dut_b (
    .clk(clk), .reset(reset), .start(st[1]),
    .value0(v0[1][WB-1:0]), .value1(v1[1][WB-1:0]),
    .str(str_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // 8-char decimal field, leftmost char in the top byte like a string literal
  function automatic logic [63:0] digits(input logic [31:0] v);
    logic [63:0] r;
    longint      lv, p;
    int          d;
    bit          seen;
    lv = {32'd0, v};
    if (lv > 64'sd99999999) return "********";
    p = 10000000;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d = int'((lv / p) % 10);
      p = p / 10;
      if (d != 0) seen = 1'b1;
      r[63-8*k -: 8] = (seen || k == 7) ? 8'h30 + 8'(d) : LEADC;
    end
    return r;
  endfunction

  function automatic logic [255:0] img(input logic [63:0] f0, input logic [63:0] f1);
    logic [255:0] r;
    logic [63:0]  a, b;
    a = L0;
    b = L1;
    for (int k = 0; k < 8; k++) begin
      r[8*k +: 8]      = a[63-8*k -: 8];
      r[8*(k+8) +: 8]  = f0[63-8*k -: 8];
      r[8*(k+16) +: 8] = b[63-8*k -: 8];
      r[8*(k+24) +: 8] = f1[63-8*k -: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] fld(input logic [255:0] s, input int base);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[63-8*k -: 8] = s[8*(base+k) +: 8];
    return r;
  endfunction

  function automatic int wid(input int i);
    return (i == 0) ? WA : WB;
  endfunction

  function automatic logic dn(input int i);
    return (i == 0) ? done_a : done_b;
  endfunction

  // reference model: busy window of 2*(W+9)+1 edges, then commit
  logic [255:0] m_str  [2];
  logic         m_busy [2];
  logic         m_done [2];
  logic [1:0]   m_ovf  [2];
  logic [31:0]  m_v0   [2];
  logic [31:0]  m_v1   [2];
  int           m_cnt  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_str[i]  = img(SP8, SP8);
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_ovf[i]  = 2'b00;
        m_cnt[i]  = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_str[i]  = img(digits(m_v0[i]), digits(m_v1[i]));
            m_ovf[i]  = {m_v1[i] > 32'd99999999, m_v0[i] > 32'd99999999};
            m_done[i] = 1'b1;
            m_busy[i] = 1'b0;
          end
        end else if (st[i]) begin
          m_v0[i]   = v0[i];
          m_v1[i]   = v1[i];
          m_busy[i] = 1'b1;
          m_cnt[i]  = 2 * (wid(i) + 9) + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("cmp_str_a",  str_a, m_str[0]);
      chk("cmp_busy_a", 256'(busy_a), 256'(m_busy[0]));
      chk("cmp_done_a", 256'(done_a), 256'(m_done[0]));
      chk("cmp_ovf_a",  256'(ovf_a), 256'(m_ovf[0]));
      chk("cmp_str_b",  str_b, m_str[1]);
      chk("cmp_busy_b", 256'(busy_b), 256'(m_busy[1]));
      chk("cmp_done_b", 256'(done_b), 256'(m_done[1]));
      chk("cmp_ovf_b",  256'(ovf_b), 256'(m_ovf[1]));
    end
  end

  // start across edge E0; optional re-start before E(re_at), reset pulse at E(rst_at)
  task automatic conv(input int i, input logic [31:0] a, input logic [31:0] b,
                      input int re_at, input int rst_at, output int lat, output int nd);
    int n;
    @(negedge clk); #1;
    v0[i] = a;
    v1[i] = b;
    st[i] = 1'b1;
    lat = -1;
    nd  = 0;
    n   = 0;
    while (n < 2 * (wid(i) + 9) + 6) begin
      @(negedge clk);
      n++;
      if (dn(i)) begin
        nd++;
        if (lat < 0) lat = n - 1;
      end
      #1;
      st[i] = (n == re_at);
      if (n == re_at) v0[i] = 32'd99;
      reset = (n == rst_at);
    end
  endtask

  initial begin
    int lat, nd;
    st[0] = 1'b0; st[1] = 1'b0;
    v0[0] = '0; v1[0] = '0; v0[1] = '0; v1[1] = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_label0", 256'(fld(str_a, 0)),  256'(L0));
    chk("rst_dig0",   256'(fld(str_a, 8)),  256'(SP8));
    chk("rst_label1", 256'(fld(str_a, 16)), 256'(L1));
    chk("rst_dig1",   256'(fld(str_a, 24)), 256'(SP8));
    chk("rst_busy",   256'(busy_a), 256'(0));
    chk("rst_done",   256'(done_a), 256'(0));
    chk("rst_ovf",    256'(ovf_a),  256'(0));

    conv(0, 32'd0, 32'd0, 0, 0, lat, nd);
    chk("t1_latency", 256'(lat), 256'(67));
    chk("t1_ndone",   256'(nd),  256'(1));
    chk("t1_dig0",    256'(fld(str_a, 8)),  256'(E_ZERO));
    chk("t1_dig1",    256'(fld(str_a, 24)), 256'(E_ZERO));
    chk("t1_ovf",     256'(ovf_a), 256'(0));

    conv(0, 32'd1234567, 32'd16777215, 0, 0, lat, nd);
    chk("t2_dig0",    256'(fld(str_a, 8)),  256'(E_1234));
    chk("t2_dig1",    256'(fld(str_a, 24)), 256'("16777215"));
    chk("t2_label0",  256'(fld(str_a, 0)),  256'(L0));
    chk("t2_label1",  256'(fld(str_a, 16)), 256'(L1));
    chk("t2_ovf",     256'(ovf_a), 256'(0));

    conv(1, 32'd100000000, 32'd5, 0, 0, lat, nd);
    chk("t3_latency", 256'(lat), 256'(75));
    chk("t3_dig0",    256'(fld(str_b, 8)),  256'("********"));
    chk("t3_dig1",    256'(fld(str_b, 24)), 256'(E_5));
    chk("t3_ovf",     256'(ovf_b), 256'(2'b01));

    conv(0, 32'd11, 32'd0, 10, 0, lat, nd);
    chk("t4_ndone",   256'(nd),  256'(1));
    chk("t4_latency", 256'(lat), 256'(67));
    chk("t4_dig0",    256'(fld(str_a, 8)), 256'(E_11));

    conv(0, 32'd123, 32'd456, 0, 30, lat, nd);
    chk("t5_ndone",   256'(nd), 256'(0));
    chk("t5_busy",    256'(busy_a), 256'(0));
    chk("t5_str",     str_a, img(SP8, SP8));
    chk("t5_ovf",     256'(ovf_a), 256'(0));
    conv(0, 32'd7, 32'd8, 0, 0, lat, nd);
    chk("t5_relat",   256'(lat), 256'(67));

    conv(0, 32'd42, 32'd0, 0, 0, lat, nd);
    chk("t6_dig0",    256'(fld(str_a, 8)), 256'(E_42));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
